// File: rtl/seg7_scan_driver_if.sv
// Display bus between the datapath (master) and the 7-segment scan driver (slave).
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 8
);
   logic                    en;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] data;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lzs_en;
   logic [3:0]              brightness;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

   modport master (
      output en, load, data, dp_mask, blank_mask, lzs_en, brightness,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  en, load, data, dp_mask, blank_mask, lzs_en, brightness,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: per-slot PWM brightness, double-buffered
// digit data, DP/blank masks, leading-zero suppression and a frame strobe.
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int SLOT_CYCLES = 100_000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   seg7_scan_driver_if.slave bus
);
   localparam int CW = $clog2(SLOT_CYCLES);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] UNIT      = CW'(SLOT_CYCLES / 16);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] IDX_FIRST = IW'(NUM_DIGITS - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
   localparam logic       DP_POL  = ACTIVE_LOW;

   typedef enum logic [0:0] {ST_ON = 1'b0, ST_OFF = 1'b1} state_t;

   // Standard hex glyphs, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         4'hF:    g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   state_t                  state_r, state_s;
   logic [CW-1:0]           cnt_r, cnt_inc_s, on_cycles_s;
   logic [IW-1:0]           idx_r;
   logic [3:0]              bright_r, bright_s;
   logic                    slot_end_s, frame_end_s;
   logic [4*NUM_DIGITS-1:0] active_data_r, shadow_data_r;
   logic [NUM_DIGITS-1:0]   active_dp_r, shadow_dp_r, active_blank_r, shadow_blank_r;
   logic                    pending_r, wrap_r;
   logic [NUM_DIGITS-1:0]   lead_zero_s, an_s, an_r;
   logic [6:0]              seg_s, seg_r;
   logic                    dp_s, dp_r, frame_done_r, dark_s;
   logic [3:0]              nib_s;

   // Slot timing: brightness is taken live on the first cycle of a slot and held after.
   always_comb begin
      slot_end_s  = (cnt_r == SLOT_LAST);
      frame_end_s = slot_end_s && (idx_r == {IW{1'b0}});
      cnt_inc_s   = cnt_r + CNT_ONE;
      if (cnt_r == {CW{1'b0}}) begin
         bright_s = bus.brightness;
      end else begin
         bright_s = bright_r;
      end
      on_cycles_s = UNIT * CW'(bright_s);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_ON;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state: every slot opens in ON and drops to OFF once on_cycles are spent.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_ON: begin
            if (slot_end_s) begin
               state_s = ST_ON;
            end else if (cnt_inc_s >= on_cycles_s) begin
               state_s = ST_OFF;
            end else begin
               state_s = ST_ON;
            end
         end
         ST_OFF: begin
            if (slot_end_s) begin
               state_s = ST_ON;
            end else begin
               state_s = ST_OFF;
            end
         end
         default: state_s = ST_ON;
      endcase
   end

   // Slot counter, digit index (scans downwards) and held brightness.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= {CW{1'b0}};
         idx_r    <= IDX_FIRST;
         bright_r <= 4'h0;
      end else begin
         bright_r <= bright_s;
         if (slot_end_s) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= (idx_r == {IW{1'b0}}) ? IDX_FIRST : (idx_r - IDX_ONE);
         end else begin
            cnt_r <= cnt_inc_s;
         end
      end
   end

   // Double buffer: shadow swaps into active only at a frame boundary, so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_data_r  <= {(4*NUM_DIGITS){1'b0}};
         active_dp_r    <= {NUM_DIGITS{1'b0}};
         active_blank_r <= {NUM_DIGITS{1'b0}};
         shadow_data_r  <= {(4*NUM_DIGITS){1'b0}};
         shadow_dp_r    <= {NUM_DIGITS{1'b0}};
         shadow_blank_r <= {NUM_DIGITS{1'b0}};
         pending_r      <= 1'b0;
      end else begin
         if (frame_end_s && pending_r) begin
            active_data_r  <= shadow_data_r;
            active_dp_r    <= shadow_dp_r;
            active_blank_r <= shadow_blank_r;
         end
         if (bus.load) begin
            shadow_data_r  <= bus.data;
            shadow_dp_r    <= bus.dp_mask;
            shadow_blank_r <= bus.blank_mask;
            pending_r      <= 1'b1;
         end else if (frame_end_s) begin
            pending_r      <= 1'b0;
         end
      end
   end

   // Leading-zero map: bit i set when every digit from the top down to i is zero.
   always_comb begin : lead_zero_scan
      logic run;
      run         = 1'b1;
      lead_zero_s = {NUM_DIGITS{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run            = run && (active_data_r[4*i +: 4] == 4'h0);
         lead_zero_s[i] = run;
      end
   end

   // FSM outputs in lit-level polarity: the current digit during ON, everything dark otherwise.
   always_comb begin
      nib_s  = active_data_r[{idx_r, 2'b00} +: 4];
      dark_s = active_blank_r[idx_r] ||
               (bus.lzs_en && (idx_r != {IW{1'b0}}) && lead_zero_s[idx_r]);
      an_s   = {NUM_DIGITS{1'b0}};
      seg_s  = 7'h00;
      dp_s   = 1'b0;
      if (bus.en && (state_r == ST_ON) && (on_cycles_s != {CW{1'b0}})) begin
         an_s[idx_r] = 1'b1;
         if (dark_s) begin
            seg_s = 7'h00;
         end else begin
            seg_s = hex_glyph(nib_s);
         end
         if (active_blank_r[idx_r]) begin
            dp_s = 1'b0;
         end else begin
            dp_s = active_dp_r[idx_r];
         end
      end else begin
         an_s  = {NUM_DIGITS{1'b0}};
         seg_s = 7'h00;
         dp_s  = 1'b0;
      end
   end

   // Pin registers: anode and segment data leave together; frame_done lines up with the new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_r         <= AN_POL;
         seg_r        <= SEG_POL;
         dp_r         <= DP_POL;
         wrap_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         an_r         <= an_s ^ AN_POL;
         seg_r        <= seg_s ^ SEG_POL;
         dp_r         <= dp_s ^ DP_POL;
         wrap_r       <= frame_end_s;
         frame_done_r <= wrap_r;
      end
   end

   assign bus.an         = an_r;
   assign bus.seg        = seg_r;
   assign bus.dp         = dp_r;
   assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: an active-low and an active-high driver share stimulus and
// are compared every cycle against a time-based reference model.
module tb_seg7_scan_driver;
   localparam int ND = 4;
   localparam int SC = 32;
   localparam int FR = ND * SC;
   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_lo ();
   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus_hi ();

   seg7_scan_driver #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .ACTIVE_LOW(1'b1)) dut_lo (
      .clk(clk), .rst(rst), .bus(bus_lo));
   seg7_scan_driver #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC), .ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk), .rst(rst), .bus(bus_hi));

   assign bus_hi.en         = bus_lo.en;
   assign bus_hi.load       = bus_lo.load;
   assign bus_hi.data       = bus_lo.data;
   assign bus_hi.dp_mask    = bus_lo.dp_mask;
   assign bus_hi.blank_mask = bus_lo.blank_mask;
   assign bus_hi.lzs_en     = bus_lo.lzs_en;
   assign bus_hi.brightness = bus_lo.brightness;

   logic [12:0] obs_lo, obs_hi, exp_lo, exp_hi;
   assign obs_lo = {bus_lo.an, bus_lo.seg, bus_lo.dp, bus_lo.frame_done};
   assign obs_hi = {bus_hi.an, bus_hi.seg, bus_hi.dp, bus_hi.frame_done};

   int          t;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_act_data, m_sh_data;
   logic [3:0]  m_act_dp, m_act_blank, m_sh_dp, m_sh_blank, m_bright;
   logic        m_pending;

   // Reference model: predicts the pins of the next cycle from time t and the live inputs,
   // then applies the buffer rules for the coming edge and advances one clock.
   task automatic tick();
      int         cnt, idx;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp, e_fd, dark;
      e_an = 4'h0; e_seg = 7'h00; e_dp = 1'b0; e_fd = 1'b0;
      if (rst) begin
         t = 0;
         m_act_data = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'h0;
         m_sh_data  = 16'h0; m_sh_dp  = 4'h0; m_sh_blank  = 4'h0;
         m_pending  = 1'b0;  m_bright = 4'h0;
      end else begin
         cnt = t % SC;
         idx = ND - 1 - ((t / SC) % ND);
         if (cnt == 0) m_bright = bus_lo.brightness;
         if (bus_lo.en && (cnt < (SC / 16) * int'(m_bright))) begin
            e_an[idx] = 1'b1;
            dark  = m_act_blank[idx] ||
                    (bus_lo.lzs_en && idx != 0 && ((m_act_data >> (4 * idx)) == 16'h0));
            e_seg = dark ? 7'h00 : GLYPH[m_act_data[4*idx +: 4]];
            e_dp  = m_act_dp[idx] && !m_act_blank[idx];
         end
         e_fd = ((t % FR) == 0) && (t >= FR);
         if ((t % FR) == FR - 1 && m_pending) begin
            m_act_data = m_sh_data; m_act_dp = m_sh_dp; m_act_blank = m_sh_blank;
         end
         if (bus_lo.load) begin
            m_sh_data = bus_lo.data; m_sh_dp = bus_lo.dp_mask; m_sh_blank = bus_lo.blank_mask;
            m_pending = 1'b1;
         end else if ((t % FR) == FR - 1) begin
            m_pending = 1'b0;
         end
         t++;
      end
      exp_lo = {~e_an, ~e_seg, ~e_dp, e_fd};
      exp_hi = {e_an, e_seg, e_dp, e_fd};
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus_lo.en = 1'b1; bus_lo.load = 1'b0; bus_lo.data = 16'hFFFF;
      bus_lo.dp_mask = 4'hF; bus_lo.blank_mask = 4'h0; bus_lo.lzs_en = 1'b0; bus_lo.brightness = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (obs_lo !== exp_lo || obs_lo !== 13'b1111_1111111_1_0) begin
            n_fail++; $display("FAIL reset_lo: got %b want %b", obs_lo, exp_lo);
         end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL reset_hi: got %b want %b", obs_hi, exp_hi); end
      end
   endtask

   task automatic test_basic();
      logic seen = 1'b0;
      rst = 1'b0; bus_lo.data = 16'h12AF; bus_lo.dp_mask = 4'h0; bus_lo.load = 1'b1;
      for (int k = 0; k < 4 * FR; k++) begin
         if (k > 0) bus_lo.load = 1'b0;
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL basic_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL basic_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
         if (!seen && bus_lo.frame_done === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if ({bus_lo.an, bus_lo.seg} !== {4'b0111, 7'b1111001}) begin
               n_fail++; $display("FAIL first_digit_lo: got %b want %b", {bus_lo.an, bus_lo.seg}, {4'b0111, 7'b1111001});
            end
            n_checks++;
            if ({bus_hi.an, bus_hi.seg} !== {4'b1000, 7'b0000110}) begin
               n_fail++; $display("FAIL first_digit_hi: got %b want %b", {bus_hi.an, bus_hi.seg}, {4'b1000, 7'b0000110});
            end
         end
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL frame_done_timeout: got 0 pulses want >=1"); end
   endtask

   task automatic test_brightness();
      for (int k = 0; k < 6 * FR; k++) begin
         if (k == 0)      bus_lo.brightness = 4'd4;
         if (k == 2 * FR) bus_lo.brightness = 4'd0;
         if (k >= 4 * FR && (k % SC) == 7) bus_lo.brightness = 4'($urandom_range(0, 15));
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL bright_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL bright_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
      end
      bus_lo.brightness = 4'd15;
   endtask

   task automatic test_lzs();
      for (int k = 0; k < 6 * FR; k++) begin
         bus_lo.load = 1'b0;
         if (k == 0)      begin bus_lo.data = 16'h0005; bus_lo.lzs_en = 1'b1; bus_lo.load = 1'b1; end
         if (k == 2 * FR) begin bus_lo.data = 16'h0000; bus_lo.load = 1'b1; end
         if (k == 4 * FR) bus_lo.lzs_en = 1'b0;
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL lzs_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL lzs_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
      end
   endtask

   task automatic test_double_buffer();
      int phase = 0;
      for (int k = 0; k < 9 * FR; k++) begin
         bus_lo.load = 1'b0;
         if (k == 0) begin
            bus_lo.data = 16'h1234; bus_lo.load = 1'b1;
         end else if (k >= 2 * FR && phase == 0 && (t % FR) == 40) begin
            bus_lo.data = 16'h8888; bus_lo.load = 1'b1; phase = 1;
         end else if (k >= 4 * FR && phase == 1 && (t % FR) == FR - 1) begin
            bus_lo.data = 16'h5A5A; bus_lo.load = 1'b1; phase = 2;
         end else if (k >= 6 * FR && phase == 2 && (t % FR) == 1) begin
            bus_lo.data = 16'h0F0F; bus_lo.load = 1'b1; phase = 3;
         end else if (k >= 7 * FR && phase == 3 && (t % FR) == 10) begin
            bus_lo.data = 16'h1111; bus_lo.load = 1'b1; phase = 4;
         end else if (phase == 4) begin
            bus_lo.data = 16'h2222; bus_lo.load = 1'b1; phase = 5;
         end else begin
            bus_lo.data = 16'($urandom);
         end
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL dbuf_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL dbuf_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
      end
   endtask

   task automatic test_masks_en();
      for (int k = 0; k < 4 * FR; k++) begin
         bus_lo.load = 1'b0;
         if (k == 0) begin
            bus_lo.data = 16'h9C3E; bus_lo.dp_mask = 4'b0100; bus_lo.blank_mask = 4'b0001; bus_lo.load = 1'b1;
         end
         if (k >= 2 * FR) bus_lo.en = ($urandom_range(0, 3) != 0);
         if (k == 2 * FR + 37) bus_lo.en = 1'b0;
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL mask_en_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL mask_en_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
      end
      bus_lo.en = 1'b1;
   endtask

   task automatic test_rst_mid();
      int phase = 0;
      bus_lo.dp_mask = 4'h0; bus_lo.blank_mask = 4'h0; bus_lo.lzs_en = 1'b0;
      for (int k = 0; k < 4 * FR; k++) begin
         rst = 1'b0; bus_lo.load = 1'b0;
         if (k == 0) begin bus_lo.data = 16'h4321; bus_lo.load = 1'b1; end
         if (phase == 0 && k >= 2 * FR && (t % FR) == 2 * SC + 5) begin rst = 1'b1; phase = 1; end
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL rst_mid_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL rst_mid_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
         if (phase == 1 && t == 1) begin
            phase = 2;
            n_checks++;
            if ({bus_lo.an, bus_lo.seg} !== {4'b0111, 7'b1000000}) begin
               n_fail++; $display("FAIL rst_restart: got %b want %b", {bus_lo.an, bus_lo.seg}, {4'b0111, 7'b1000000});
            end
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 24 * FR; k++) begin
         bus_lo.load = ($urandom_range(0, 47) == 0);
         if (bus_lo.load) begin
            bus_lo.data = 16'($urandom); bus_lo.dp_mask = 4'($urandom); bus_lo.blank_mask = 4'($urandom);
            if ($urandom_range(0, 1) == 0) bus_lo.data = bus_lo.data & 16'h00FF;
         end
         if ($urandom_range(0, 99) == 0) bus_lo.brightness = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) bus_lo.lzs_en = ~bus_lo.lzs_en;
         bus_lo.en = ($urandom_range(0, 19) != 0);
         tick();
         n_checks++;
         if (obs_lo !== exp_lo) begin n_fail++; $display("FAIL random_lo t=%0d: got %b want %b", t, obs_lo, exp_lo); end
         n_checks++;
         if (obs_hi !== exp_hi) begin n_fail++; $display("FAIL random_hi t=%0d: got %b want %b", t, obs_hi, exp_hi); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_brightness();
      test_lzs();
      test_double_buffer();
      test_masks_en();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment scan driver, the successor to the fixed 8-digit, 1 ms-slot display driver. It supports any digit count, a programmable slot length and output polarity, and 16-level brightness PWM. It adds double-buffered tear-free updates, per-digit DP and blank masks, leading-zero suppression, and a frame-done strobe. It sits between the cipher/temperature datapath and the board's CA..CG/DP/AN pins.

Parameters:
NUM_DIGITS, 8, number of digits/anodes (1..16)
SLOT_CYCLES, 100_000, clk cycles per digit slot (1 ms at 100 MHz); must be a multiple of 16 and at least 32
ACTIVE_LOW, 1, 1 = segments/DP/anodes driven low when lit; 0 = high when lit

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  display enable; 0 forces all outputs to their unlit level
load  in  1  one-cycle strobe; captures data/dp_mask/blank_mask into shadow buffer
data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i]
dp_mask  in  NUM_DIGITS  1 = light DP of digit i
blank_mask  in  NUM_DIGITS  1 = force digit i dark
lzs_en  in  1  leading-zero suppression enable (level, read live)
brightness  in  4  on-time in sixteenths of a slot; 0 = dark
seg  out  7  {CG,CF,CE,CD,CC,CB,CA}, seg[0]=CA
dp  out  1  decimal point
an  out  NUM_DIGITS  anode enables, an[i] = digit i
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (sync, rst=1): an, seg, dp at unlit level; frame_done=0; slot counter=0; digit index=NUM_DIGITS-1; active and shadow buffers=0; pending=0; FSM=ON.
- Scan order: digit NUM_DIGITS-1 first, down to digit 0, then wrap. One slot = SLOT_CYCLES clocks.
- brightness is sampled at slot start (slot counter=0), giving on_cycles = (SLOT_CYCLES/16)*brightness.
- FSM per slot:
  - ON: digit lit for on_cycles.
  - OFF: all anodes unlit for the remaining cycles. At least SLOT_CYCLES/16 off cycles are always present (ghost-blanking).
  - brightness=0 skips ON.
- Slot end advances the digit index. Leaving digit 0 wraps to NUM_DIGITS-1 and pulses frame_done for exactly one cycle, coincident with the first cycle of the new frame.
- Outputs are registered. an, seg and dp change in the same cycle, with no skew between anode and segment data. Latency from an FSM/index change to the pins is 1 clk.
- Glyphs use standard hex: 0-9, A, b, C, d, E, F. ACTIVE_LOW inverts all outputs uniformly.
- Digit i is shown dark (an lit, seg and dp unlit) when any of these holds:
  - blank_mask[i]=1, or
  - lzs_en=1 and digits NUM_DIGITS-1..i all read 0 and i != 0.
- Digit 0 is never suppressed by LZS. dp_mask[i] overrides LZS blanking for dp only.
- Double buffering:
  - load copies data/masks into the shadow buffer and sets pending.
  - At the frame boundary with pending=1: active <= shadow, pending <= 0.
  - load in the same cycle as the boundary: the old shadow transfers, the new values are captured, and pending stays 1 (they show next frame).
  - Back-to-back loads: last one wins.
- en=0: outputs are forced unlit next cycle. Counters, FSM, load and frame_done keep running, so re-enabling resumes mid-frame without a restart.
- rst mid-slot or mid-frame aborts immediately to reset state. Next-cycle outputs are unlit, and the scan restarts at digit NUM_DIGITS-1.

Test Plan:
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=32, ACTIVE_LOW=1 unless stated.
1. Reset, then load data=16'h12AF, brightness=15, en=1. Next frame: an=0111 for 30 clks with seg=1111001 ("1"); 2 clks an=1111; then 1011 with "2", 1101 with "A", 1110 with seg=0001110 ("F"). frame_done is high every 128 clks, one cycle wide.
2. brightness=4: each slot shows an lit for 8 clks then 24 clks off. brightness=0: an=1111 for the entire frame.
3. data=16'h0005, lzs_en=1: digits 3..1 dark (seg=1111111), digit 0 shows "5". data=16'h0000: only digit 0 lit with "0". Same data with lzs_en=0: all four show "0" (seg=1000000).
4. Drive load mid-frame with 16'h8888 while the active buffer holds 16'h1234: the rest of the frame still shows 1,2,3,4, and "8" appears from the next frame start. A load coincident with frame_done is deferred one further frame.
5. dp_mask=4'b0100, blank_mask=4'b0001: dp=0 only during the digit-2 slot; digit 0 is dark. en deasserted mid-slot gives an=1111 and seg=1111111 next clk, while frame_done keeps its 128-clk period.
6. Assert rst during the digit-1 ON phase: next clk outputs are unlit, and the scan restarts at digit 3 with the buffers cleared (shows "0000").
7. Repeat scenario 1 with ACTIVE_LOW=0: all outputs are bitwise inverted.
